// File: rtl/simpletest_arb.sv
// simpletest_arb: round-robin two-port arbiter and sequencer for the simpletest datapath.
// Define SIMPLETEST_ARB_STATS_EN to add the per-requester grant counters gnt_cnt0/gnt_cnt1.
module simpletest_arb #(
  parameter int WIDTH = 8,
  parameter int LAT   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_op1,
  input  logic [WIDTH-1:0] req0_op2,
  input  logic [1:0]       req0_sel,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_op1,
  input  logic [WIDTH-1:0] req1_op2,
  input  logic [1:0]       req1_sel,
  output logic [WIDTH-1:0] dp_op1,
  output logic [WIDTH-1:0] dp_op2,
  output logic [1:0]       dp_sel,
  output logic             dp_key,
  input  logic [WIDTH-1:0] dp_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy
`ifdef SIMPLETEST_ARB_STATS_EN
  ,
  output logic [15:0]      gnt_cnt0,
  output logic [15:0]      gnt_cnt1
`endif
);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

  localparam logic [3:0] LAT_CNT = 4'(LAT);

  generate
    if (LAT < 1 || LAT > 15) begin : g_lat_check
      $error("simpletest_arb: LAT must be in 1..15");
    end
  endgenerate

  state_t           state_reg, state_next;
  logic [3:0]       cnt_reg, cnt_next;
  logic             gnt_id_reg;
  logic             last_id_reg;
  logic [WIDTH-1:0] dp_op1_reg, dp_op2_reg;
  logic [1:0]       dp_sel_reg;
  logic             dp_key_reg;
  logic [WIDTH-1:0] rsp_data_reg;
  logic             rsp_id_reg;

  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic             win_id;
  logic             grant;
  logic             capture;
  logic [WIDTH-1:0] win_op1, win_op2;
  logic [1:0]       win_sel;

  assign req_valid = {req1_valid, req0_valid};

  // A lone requester always wins; under contention the one not served last wins.
  always_comb begin
    win_id = 1'b0;
    if (req_valid == 2'b10) begin
      win_id = 1'b1;
    end else if (req_valid == 2'b11) begin
      win_id = ~last_id_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ready
      assign req_ready[gi] = (state_reg == IDLE) && req_valid[gi] && (int'(win_id) == gi);
    end
  endgenerate

  assign grant   = |req_ready;
  assign win_op1 = win_id ? req1_op1 : req0_op1;
  assign win_op2 = win_id ? req1_op2 : req0_op2;
  assign win_sel = win_id ? req1_sel : req0_sel;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    capture    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (grant) begin
          state_next = WAIT;
          cnt_next   = LAT_CNT;
        end
      end
      WAIT: begin
        cnt_next = cnt_reg - 4'd1;
        if (cnt_reg == 4'd1) begin
          capture    = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= 4'd0;
      gnt_id_reg   <= 1'b0;
      last_id_reg  <= 1'b1;
      dp_op1_reg   <= '0;
      dp_op2_reg   <= '0;
      dp_sel_reg   <= 2'd0;
      dp_key_reg   <= 1'b0;
      rsp_data_reg <= '0;
      rsp_id_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      // All datapath inputs load together so the datapath never sees a mixed operand set.
      if (grant) begin
        dp_op1_reg  <= win_op1;
        dp_op2_reg  <= win_op2;
        dp_sel_reg  <= win_sel;
        dp_key_reg  <= key;
        gnt_id_reg  <= win_id;
        last_id_reg <= win_id;
      end
      if (capture) begin
        rsp_data_reg <= dp_result;
        rsp_id_reg   <= gnt_id_reg;
      end
    end
  end

  assign req0_ready = req_ready[0];
  assign req1_ready = req_ready[1];
  assign dp_op1     = dp_op1_reg;
  assign dp_op2     = dp_op2_reg;
  assign dp_sel     = dp_sel_reg;
  assign dp_key     = dp_key_reg;
  assign rsp_valid  = (state_reg == RESP);
  assign rsp_data   = rsp_data_reg;
  assign rsp_id     = rsp_id_reg;
  assign busy       = (state_reg != IDLE);

`ifdef SIMPLETEST_ARB_STATS_EN
  logic [15:0] gnt_cnt_reg [2];

  generate
    for (gi = 0; gi < 2; gi++) begin : g_stats
      always_ff @(posedge clk) begin
        if (!rst) begin
          gnt_cnt_reg[gi] <= 16'd0;
        end else if (req_ready[gi] && (gnt_cnt_reg[gi] != 16'hFFFF)) begin
          gnt_cnt_reg[gi] <= gnt_cnt_reg[gi] + 16'd1;
        end
      end
    end
  endgenerate

  assign gnt_cnt0 = gnt_cnt_reg[0];
  assign gnt_cnt1 = gnt_cnt_reg[1];
`endif

endmodule

// File: tb/tb_simpletest_arb.sv
// Directed bench for simpletest_arb: LAT=1 instance for arbitration/handshake scenarios,
// LAT=4 instance for capture timing. Stats checks compile only with SIMPLETEST_ARB_STATS_EN.
module tb_simpletest_arb;

  logic       clk = 1'b0;
  logic       rst;
  logic       key;
  logic       req0_valid, req1_valid;
  logic       req0_ready, req1_ready;
  logic [7:0] req0_op1, req0_op2, req1_op1, req1_op2;
  logic [1:0] req0_sel, req1_sel;
  logic [7:0] dp_op1, dp_op2, dp_result;
  logic [1:0] dp_sel;
  logic       dp_key;
  logic       rsp_valid, rsp_ready, rsp_id;
  logic [7:0] rsp_data;
  logic       busy;

  logic       r4_valid, r4_ready, r4_ready1;
  logic [7:0] dp4_op1, dp4_op2, dp4_result;
  logic [1:0] dp4_sel;
  logic       dp4_key;
  logic       rsp4_valid, rsp4_ready, rsp4_id;
  logic [7:0] rsp4_data;
  logic       busy4;
  logic [7:0] pert;

`ifdef SIMPLETEST_ARB_STATS_EN
  logic [15:0] gnt_cnt0, gnt_cnt1, gnt4_cnt0, gnt4_cnt1;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Datapath model: sum of the registered operands.
  assign dp_result  = dp_op1 + dp_op2;
  assign dp4_result = dp4_op1 + dp4_op2 + pert;

  simpletest_arb #(.WIDTH(8), .LAT(1)) dut (
    .clk(clk), .rst(rst), .key(key),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_op1(req0_op1), .req0_op2(req0_op2), .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_op1(req1_op1), .req1_op2(req1_op2), .req1_sel(req1_sel),
    .dp_op1(dp_op1), .dp_op2(dp_op2), .dp_sel(dp_sel), .dp_key(dp_key),
    .dp_result(dp_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .busy(busy)
`ifdef SIMPLETEST_ARB_STATS_EN
    , .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
`endif
  );

  simpletest_arb #(.WIDTH(8), .LAT(4)) dut4 (
    .clk(clk), .rst(rst), .key(key),
    .req0_valid(r4_valid), .req0_ready(r4_ready),
    .req0_op1(req0_op1), .req0_op2(req0_op2), .req0_sel(req0_sel),
    .req1_valid(1'b0), .req1_ready(r4_ready1),
    .req1_op1(req1_op1), .req1_op2(req1_op2), .req1_sel(req1_sel),
    .dp_op1(dp4_op1), .dp_op2(dp4_op2), .dp_sel(dp4_sel), .dp_key(dp4_key),
    .dp_result(dp4_result),
    .rsp_valid(rsp4_valid), .rsp_ready(rsp4_ready), .rsp_id(rsp4_id), .rsp_data(rsp4_data),
    .busy(busy4)
`ifdef SIMPLETEST_ARB_STATS_EN
    , .gnt_cnt0(gnt4_cnt0), .gnt_cnt1(gnt4_cnt1)
`endif
  );

  // Holds rst low across two rising edges; returns at the negedge starting cycle 0 with rst high.
  task automatic pulse_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; key = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    req0_op1 = 8'h00; req0_op2 = 8'h00; req0_sel = 2'd0;
    req1_op1 = 8'h00; req1_op2 = 8'h00; req1_sel = 2'd0;
    r4_valid = 1'b0; rsp4_ready = 1'b1; pert = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    checks++; if (dp_op1 !== 8'h00) begin errors++; $display("FAIL reset_dp_op1 got %h exp 00", dp_op1); end
    checks++; if (dp_op2 !== 8'h00) begin errors++; $display("FAIL reset_dp_op2 got %h exp 00", dp_op2); end
    checks++; if (dp_sel !== 2'd0) begin errors++; $display("FAIL reset_dp_sel got %h exp 0", dp_sel); end
    checks++; if (dp_key !== 1'b0) begin errors++; $display("FAIL reset_dp_key got %b exp 0", dp_key); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
    checks++; if (rsp_data !== 8'h00) begin errors++; $display("FAIL reset_rsp_data got %h exp 00", rsp_data); end
    checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL reset_rsp_id got %b exp 0", rsp_id); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    rst = 1'b1;
    $display("txn reset released");
  endtask

  task automatic test_single();
    @(negedge clk);
    req0_valid = 1'b1; req0_op1 = 8'h03; req0_op2 = 8'h04; req0_sel = 2'd1; key = 1'b1;
    #1;
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL single_ready0 got %b exp 1", req0_ready); end
    checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL single_ready1 got %b exp 0", req1_ready); end
    @(negedge clk);
    req0_valid = 1'b0; key = 1'b0; req0_op1 = 8'hEE;
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_c1 got %b exp 1", busy); end
    checks++; if (dp_op1 !== 8'h03) begin errors++; $display("FAIL single_dp_op1 got %h exp 03", dp_op1); end
    checks++; if (dp_op2 !== 8'h04) begin errors++; $display("FAIL single_dp_op2 got %h exp 04", dp_op2); end
    checks++; if (dp_sel !== 2'd1) begin errors++; $display("FAIL single_dp_sel got %h exp 1", dp_sel); end
    checks++; if (dp_key !== 1'b1) begin errors++; $display("FAIL single_dp_key got %b exp 1", dp_key); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_rsp_valid_c1 got %b exp 0", rsp_valid); end
    @(negedge clk); #1;
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_rsp_valid_c2 got %b exp 1", rsp_valid); end
    checks++; if (rsp_data !== 8'h07) begin errors++; $display("FAIL single_rsp_data got %h exp 07", rsp_data); end
    checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL single_rsp_id got %b exp 0", rsp_id); end
    @(negedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_c3 got %b exp 0", busy); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_rsp_valid_c3 got %b exp 0", rsp_valid); end
    checks++; if (dp_op1 !== 8'h03) begin errors++; $display("FAIL single_dp_hold got %h exp 03", dp_op1); end
    $display("txn single id=0 data=%h", rsp_data);
  endtask

  task automatic test_contention();
    logic       exp_r0, exp_r1, exp_v, exp_id;
    logic [7:0] exp_data;
    int         phase, turn;
    req0_op1 = 8'h11; req0_op2 = 8'h22; req0_sel = 2'd2;
    req1_op1 = 8'hF0; req1_op2 = 8'h20; req1_sel = 2'd3;
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    pulse_reset();
    // Grants every 3 cycles (LAT=1), alternating req0, req1, req0, req1.
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      phase    = c % 3;
      turn     = (c / 3) % 2;
      exp_r0   = (phase == 0) && (turn == 0);
      exp_r1   = (phase == 0) && (turn == 1);
      exp_v    = (phase == 2);
      exp_id   = (turn == 1);
      exp_data = (turn == 1) ? 8'h10 : 8'h33;
      checks++; if (req0_ready !== exp_r0) begin errors++; $display("FAIL cont_ready0 c%0d got %b exp %b", c, req0_ready, exp_r0); end
      checks++; if (req1_ready !== exp_r1) begin errors++; $display("FAIL cont_ready1 c%0d got %b exp %b", c, req1_ready, exp_r1); end
      checks++; if (rsp_valid !== exp_v) begin errors++; $display("FAIL cont_rsp_valid c%0d got %b exp %b", c, rsp_valid, exp_v); end
      if (exp_v) begin
        checks++; if (rsp_id !== exp_id) begin errors++; $display("FAIL cont_rsp_id c%0d got %b exp %b", c, rsp_id, exp_id); end
        checks++; if (rsp_data !== exp_data) begin errors++; $display("FAIL cont_rsp_data c%0d got %h exp %h", c, rsp_data, exp_data); end
        $display("txn contention id=%0d data=%h", rsp_id, rsp_data);
      end
    end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    req1_valid = 1'b1; rsp_ready = 1'b0;
    #1;
    checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL bp_ready1_grant got %b exp 1", req1_ready); end
    @(negedge clk);
    req1_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_rsp_valid k%0d got %b exp 1", k, rsp_valid); end
      checks++; if (rsp_data !== 8'h10) begin errors++; $display("FAIL bp_rsp_data k%0d got %h exp 10", k, rsp_data); end
      checks++; if (rsp_id !== 1'b1) begin errors++; $display("FAIL bp_rsp_id k%0d got %b exp 1", k, rsp_id); end
      checks++; if ({req1_ready, req0_ready} !== 2'b00) begin errors++; $display("FAIL bp_readys k%0d got %b exp 00", k, {req1_ready, req0_ready}); end
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    #1;
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_release_valid got %b exp 1", rsp_valid); end
    checks++; if (rsp_data !== 8'h10) begin errors++; $display("FAIL bp_release_data got %h exp 10", rsp_data); end
    $display("txn backpressure id=%0d data=%h", rsp_id, rsp_data);
    @(negedge clk); #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_done_valid got %b exp 0", rsp_valid); end
    checks++; if ({req1_ready, req0_ready} !== 2'b01) begin errors++; $display("FAIL bp_pending_grant got %b exp 01", {req1_ready, req0_ready}); end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_pending_busy got %b exp 1", busy); end
    @(negedge clk); #1;
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_pending_valid got %b exp 1", rsp_valid); end
    checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL bp_pending_id got %b exp 0", rsp_id); end
    checks++; if (rsp_data !== 8'h33) begin errors++; $display("FAIL bp_pending_data got %h exp 33", rsp_data); end
    $display("txn pending id=%0d data=%h", rsp_id, rsp_data);
    @(negedge clk);
  endtask

  task automatic test_latency();
    @(negedge clk);
    r4_valid = 1'b1; req0_op1 = 8'h21; req0_op2 = 8'h12; rsp4_ready = 1'b1;
    #1;
    checks++; if (r4_ready !== 1'b1) begin errors++; $display("FAIL lat_ready got %b exp 1", r4_ready); end
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      r4_valid = 1'b0;
      // Garbage on the result bus everywhere except the capture cycle.
      pert = (c == 4) ? 8'h00 : 8'h55;
      #1;
      checks++; if (rsp4_valid !== 1'b0) begin errors++; $display("FAIL lat_rsp_valid c%0d got %b exp 0", c, rsp4_valid); end
      checks++; if (busy4 !== 1'b1) begin errors++; $display("FAIL lat_busy c%0d got %b exp 1", c, busy4); end
    end
    @(negedge clk);
    pert = 8'hAA; rsp4_ready = 1'b0;
    #1;
    checks++; if (rsp4_valid !== 1'b1) begin errors++; $display("FAIL lat_rsp_valid_c5 got %b exp 1", rsp4_valid); end
    checks++; if (rsp4_data !== 8'h33) begin errors++; $display("FAIL lat_rsp_data_c5 got %h exp 33", rsp4_data); end
    checks++; if (rsp4_id !== 1'b0) begin errors++; $display("FAIL lat_rsp_id got %b exp 0", rsp4_id); end
    @(negedge clk);
    pert = 8'h0F; rsp4_ready = 1'b1;
    #1;
    checks++; if (rsp4_data !== 8'h33) begin errors++; $display("FAIL lat_rsp_data_c6 got %h exp 33", rsp4_data); end
    $display("txn latency4 id=%0d data=%h", rsp4_id, rsp4_data);
    @(negedge clk);
    pert = 8'h00;
    #1;
    checks++; if (rsp4_valid !== 1'b0) begin errors++; $display("FAIL lat_done_valid got %b exp 0", rsp4_valid); end
    checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL lat_done_busy got %b exp 0", busy4); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    req0_valid = 1'b1; req0_op1 = 8'h40; req0_op2 = 8'h02;
    #1;
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL mid_ready0 got %b exp 1", req0_ready); end
    @(negedge clk);
    req0_valid = 1'b0; rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (dp_op1 !== 8'h00) begin errors++; $display("FAIL mid_dp_op1 got %h exp 00", dp_op1); end
    checks++; if (dp_op2 !== 8'h00) begin errors++; $display("FAIL mid_dp_op2 got %h exp 00", dp_op2); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_rsp_valid got %b exp 0", rsp_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b exp 0", busy); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_no_rsp k%0d got %b exp 0", k, rsp_valid); end
    end
    $display("txn reset_mid discarded");
    @(negedge clk);
    req1_valid = 1'b1; req1_op1 = 8'h05; req1_op2 = 8'h06;
    #1;
    checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL mid_next_ready1 got %b exp 1", req1_ready); end
    @(negedge clk);
    req1_valid = 1'b0;
    @(negedge clk); #1;
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL mid_next_valid got %b exp 1", rsp_valid); end
    checks++; if (rsp_data !== 8'h0B) begin errors++; $display("FAIL mid_next_data got %h exp 0b", rsp_data); end
    checks++; if (rsp_id !== 1'b1) begin errors++; $display("FAIL mid_next_id got %b exp 1", rsp_id); end
    $display("txn after_reset id=%0d data=%h", rsp_id, rsp_data);
    @(negedge clk);
  endtask

`ifdef SIMPLETEST_ARB_STATS_EN
  task automatic do_txn(input logic id);
    @(negedge clk);
    if (id) req1_valid = 1'b1; else req0_valid = 1'b1;
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_stats();
    @(negedge clk);
    pulse_reset();
    #1;
    checks++; if (gnt_cnt0 !== 16'd0) begin errors++; $display("FAIL stats_reset0 got %h exp 0000", gnt_cnt0); end
    do_txn(1'b0); do_txn(1'b1); do_txn(1'b0); do_txn(1'b1); do_txn(1'b0);
    #1;
    checks++; if (gnt_cnt0 !== 16'd3) begin errors++; $display("FAIL stats_cnt0 got %0d exp 3", gnt_cnt0); end
    checks++; if (gnt_cnt1 !== 16'd2) begin errors++; $display("FAIL stats_cnt1 got %0d exp 2", gnt_cnt1); end
    dut.gnt_cnt_reg[0] = 16'hFFFF;
    do_txn(1'b0);
    #1;
    checks++; if (gnt_cnt0 !== 16'hFFFF) begin errors++; $display("FAIL stats_sat0 got %h exp ffff", gnt_cnt0); end
    checks++; if (gnt_cnt1 !== 16'd2) begin errors++; $display("FAIL stats_hold1 got %0d exp 2", gnt_cnt1); end
    $display("txn stats cnt0=%h cnt1=%h", gnt_cnt0, gnt_cnt1);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_latency();
    test_reset_mid();
`ifdef SIMPLETEST_ARB_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/simpletest_arb.md
# simpletest_arb

Two-port arbiter and sequencer for the shared `simpletest` arithmetic datapath. Each requester presents an operand pair and a select code over a valid/ready handshake. The block grants one requester at a time using round-robin, then registers the operands and key onto the datapath inputs. After a fixed latency it captures the datapath result and returns it, tagged with the requester id, over a valid/ready response channel.

## Interface
- `WIDTH`, 8, operand/result width (matches datapath `in1`/`in2`/`out`)
- `LAT`, 1, datapath settle cycles, 1..15; `LAT`=0 is illegal and must fail elaboration
- `clk`  in  1  clock, rising edge
- `rst`  in  1  synchronous, active-low reset (asserted when 0)
- `key`  in  1  datapath key, sampled at grant
- `req0_valid` / `req1_valid`  in  1  request present
- `req0_ready` / `req1_ready`  out  1  request accepted this cycle
- `req0_op1`, `req0_op2`, `req1_op1`, `req1_op2`  in  WIDTH  operands
- `req0_sel` / `req1_sel`  in  2  datapath select code
- `dp_op1`, `dp_op2`  out  WIDTH  registered datapath operands
- `dp_sel`  out  2  registered select
- `dp_key`  out  1  registered key
- `dp_result`  in  WIDTH  datapath output
- `rsp_valid`  out  1  response available
- `rsp_ready`  in  1  response consumer ready
- `rsp_id`  out  1  requester that owns the response
- `rsp_data`  out  WIDTH  captured result
- `busy`  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, WAIT, RESP. Reset state is IDLE.
- IDLE:
  - `reqN_ready` is asserted combinationally only for the arbitration winner.
  - When the winner's valid is high, the handshake completes at that edge: operands, `sel` and `key` load into the `dp_*` registers, `gnt_id` loads, `cnt`←`LAT`, and the FSM moves to WAIT.
- Arbitration:
  - Only one requester valid: that requester wins.
  - Both valid: the requester other than `last_id` wins.
  - `last_id` updates at each grant and resets to 1, so req0 wins the first contention.
- WAIT:
  - `cnt` decrements each cycle.
  - In the cycle with `cnt`==1, `dp_result` is captured into `rsp_data` and `rsp_id`←`gnt_id`, then the FSM moves to RESP.
- RESP:
  - `rsp_valid`=1, and `rsp_data`/`rsp_id` are held stable until `rsp_valid`&&`rsp_ready`.
  - On that handshake the FSM moves to IDLE.
- Both `reqN_ready` are 0 outside IDLE. Requests that arrive while the block is busy wait; they are never dropped.
- `dp_*` registers hold their last values between operations. The datapath is never driven with a partial update.
- Reset values: `dp_op1`=0, `dp_op2`=0, `dp_sel`=0, `dp_key`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_id`=0, `busy`=0, `reqN_ready` follows IDLE arbitration.
- Reset mid-operation: any in-flight op is discarded, no response is issued, and all outputs return to their reset values on the next edge.

## Timing
- Grant at edge of cycle 0.
- `dp_*` valid from cycle 1.
- Result captured at end of cycle `LAT`.
- `rsp_valid` high from cycle `LAT`+1.
- Earliest next grant: the cycle after the response handshake. Minimum spacing between grants is `LAT`+2 cycles.
- `rsp_ready` held high in RESP: one RESP cycle.
- `rsp_ready` low: RESP persists indefinitely and the output stays stable.
- No combinational path from `reqN_valid` to `dp_*` or `rsp_*`. The only combinational input→output path is `reqN_valid` → `reqM_ready` through the arbiter.

## Configuration
- Macro: `SIMPLETEST_ARB_STATS_EN`.
- Defined:
  - Adds outputs `gnt_cnt0` and `gnt_cnt1` (out, 16 bits each), which count completed grants per requester.
  - The counters saturate at 16'hFFFF and reset to 0.
  - A counter increments on the grant edge.
- Undefined: the ports and counters are absent, and all other behaviour is identical.

## Test plan
Bench model: `dp_result` = `dp_op1`+`dp_op2` (mod 2^`WIDTH`).

- Reset, single request: hold `rst`=0 for 2 cycles, then release. req0 {op1=8'h03, op2=8'h04, sel=1}, `LAT`=1, `rsp_ready`=1 → `req0_ready`=1 in cycle 0; `rsp_valid`=1 in cycle 2 with `rsp_data`=8'h07, `rsp_id`=0; `busy` falls in cycle 3.
- Contention: both valid continuously from reset, with req1 {8'hF0, 8'h20} → grants alternate req0, req1, req0, req1. The req1 response has `rsp_data`=8'h10 (wrap-around) and `rsp_id`=1.
- Backpressure: `rsp_ready`=0 for 5 cycles in RESP → `rsp_valid`, `rsp_data` and `rsp_id` stay constant; both `reqN_ready`=0; response completes on the first cycle `rsp_ready`=1.
- Latency: `LAT`=4 → `dp_result` captured at the end of cycle 4; `rsp_valid` in cycle 5; `dp_result` perturbations after cycle 4 do not change `rsp_data`.
- Reset mid-operation: `rst`=0 in cycle 1 of WAIT → no response is ever issued; `dp_op1`=0 and `rsp_valid`=0 after the edge; the next request completes normally.
- Stats (macro defined): 3 req0 grants and 2 req1 grants → `gnt_cnt0`=3, `gnt_cnt1`=2. Preloading a counter to 16'hFFFF then granting again keeps it at 16'hFFFF.
